// File: rtl/tt_um_hoene_led_tx_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_led_tx_pkg
// Shared definitions for the smart-LED frame transmitter:
//   - tx_state_e       : frame sequencer states
//   - LED word layout  : 30-bit word, blue[29:20], green[19:10], red[9:0]
//   - MIN_HALF_PERIOD  : smallest usable half-bit period in clk cycles
//   - manchester_level : line level for a bit in a given half
// ---------------------------------------------------------------------------
package tt_um_hoene_led_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        GAP
    } tx_state_e;

    localparam int LED_DATA_W      = 30;
    localparam int COLOUR_W        = 10;
    localparam int BLUE_LSB        = 20;
    localparam int GREEN_LSB       = 10;
    localparam int RED_LSB         = 0;
    localparam int MIN_HALF_PERIOD = 2;

    // '1' is low-then-high, '0' is high-then-low.
    function automatic logic manchester_level(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

endpackage

// File: rtl/tt_um_hoene_halfbit_timer.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_halfbit_timer
// Loadable half-bit timer. Counts 0..hp-1 while running and ticks on hp-1;
// the phase bit flips on every tick (0 = first half, 1 = second half).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_i         : latch hp_i, restart at count 0 / first half
//   hp_i           : effective half period (already clamped to >= 2)
//   run_i          : count enable
//   tick_o         : last cycle of the current half
//   phase_o        : current half
//   phase_next_o   : half that will be current after this clk edge
// ---------------------------------------------------------------------------
module tt_um_hoene_halfbit_timer
    import tt_um_hoene_led_tx_pkg::*;
#(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [HP_W-1:0] hp_i,
    input  logic            run_i,
    output logic            tick_o,
    output logic            phase_o,
    output logic            phase_next_o
);

    logic [HP_W-1:0] hp_q;
    logic [HP_W-1:0] cnt_q;
    logic            phase_q;

    assign tick_o       = run_i && (cnt_q == hp_q - HP_W'(1));
    assign phase_o      = phase_q;
    assign phase_next_o = load_i ? 1'b0 : (tick_o ? ~phase_q : phase_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            hp_q    <= HP_W'(MIN_HALF_PERIOD);
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (load_i) begin
            hp_q    <= hp_i;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (run_i) begin
            if (tick_o) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q   <= cnt_q + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/tt_um_hoene_led_frame_transmitter.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_led_frame_transmitter
// Serializes 30-bit LED words into Manchester frames:
//   preamble ('0' x PREAMBLE_LEN), start ('1'), N x DATA_W data bits MSB
//   first, then GAP_BITS bit periods driven low so the chain latches.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   half_period               : clk cycles per half bit (0/1 -> 2), sampled
//                               when a frame is accepted
//   in_valid/in_ready         : word handshake; in_data word, in_last ends frame
//   out_data, out_enable      : registered line value and pad enable
//   busy                      : not IDLE
//   underrun                  : one-cycle pulse when a mid-frame word is missing
// ---------------------------------------------------------------------------
module tt_um_hoene_led_frame_transmitter
    import tt_um_hoene_led_tx_pkg::*;
#(
    parameter int DATA_W       = LED_DATA_W,
    parameter int HP_W         = 8,
    parameter int PREAMBLE_LEN = 8,
    parameter int GAP_BITS     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HP_W-1:0]   half_period,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_data,
    output logic              out_enable,
    output logic              busy,
    output logic              underrun
);

    // One bit counter is shared by preamble, data and gap; 5 bits covers all.
    localparam int            CNT_W    = 5;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              out_data_q, out_data_d;
    logic              out_enable_q, out_enable_d;
    logic              underrun_q, underrun_d;
    logic              ready_d;
    logic              load;
    logic              tick, phase, phase_next;
    logic              end_of_bit;
    logic [HP_W-1:0]   hp_eff;

    assign hp_eff = (half_period < HP_W'(MIN_HALF_PERIOD)) ? HP_W'(MIN_HALF_PERIOD) : half_period;

    tt_um_hoene_halfbit_timer #(
        .HP_W (HP_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .hp_i         (hp_eff),
        .run_i        (state_q != IDLE),
        .tick_o       (tick),
        .phase_o      (phase),
        .phase_next_o (phase_next)
    );

    assign end_of_bit = tick && phase;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = 1'b0;
        ready_d    = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (in_valid) begin
                    shift_d   = in_data;
                    last_d    = in_last;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                    state_d   = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (end_of_bit) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            START: begin
                if (end_of_bit) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (end_of_bit) begin
                    if (bit_cnt_q == DAT_LAST) begin
                        bit_cnt_d = '0;
                        if (!last_q) begin
                            // Only window where a follow-on word can be taken,
                            // so consecutive words abut with no idle bit.
                            ready_d = 1'b1;
                            if (in_valid) begin
                                shift_d = in_data;
                                last_d  = in_last;
                            end else begin
                                underrun_d = 1'b1;
                                state_d    = GAP;
                            end
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (end_of_bit) begin
                    if (bit_cnt_q == GAP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line registers take the level of the position being entered,
        // so out_data is aligned with state_q/timer in the following cycle.
        out_enable_d = (state_d != IDLE);
        case (state_d)
            PREAMBLE: out_data_d = manchester_level(1'b0, phase_next);
            START:    out_data_d = manchester_level(1'b1, phase_next);
            DATA:     out_data_d = manchester_level(shift_d[DATA_W-1], phase_next);
            default:  out_data_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            last_q       <= 1'b0;
            bit_cnt_q    <= '0;
            out_data_q   <= 1'b0;
            out_enable_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            bit_cnt_q    <= bit_cnt_d;
            out_data_q   <= out_data_d;
            out_enable_q <= out_enable_d;
            underrun_q   <= underrun_d;
        end
    end

    assign in_ready   = ready_d;
    assign out_data   = out_data_q;
    assign out_enable = out_enable_q;
    assign busy       = (state_q != IDLE);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_tt_um_hoene_led_frame_transmitter.sv
module tb_tt_um_hoene_led_frame_transmitter;

    localparam int DATA_W = 30;
    localparam int HP_W   = 8;
    localparam int PRE    = 8;
    localparam int GAPB   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [HP_W-1:0]   half_period;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_data;
    logic              out_enable;
    logic              busy;
    logic              underrun;

    always #5 clk = ~clk;

    tt_um_hoene_led_frame_transmitter dut (
        .clk         (clk),
        .rst         (rst),
        .half_period (half_period),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_data    (out_data),
        .out_enable  (out_enable),
        .busy        (busy),
        .underrun    (underrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    // Scoreboard: per-cycle expected line level while enabled, and the
    // expected enable-high length of each frame.
    logic exp_q[$];
    int   len_q[$];

    int cyc       = 0;
    int run       = 0;
    int und_cnt   = 0;
    int und_run   = 0;
    int rdy_busy  = 0;
    bit mon_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff_hp(input int hp);
        return (hp < 2) ? 2 : hp;
    endfunction

    task automatic push_bit(input logic b, input int hp);
        for (int h = 0; h < 2; h++)
            for (int k = 0; k < hp; k++)
                exp_q.push_back(h == 0 ? ~b : b);
    endtask

    task automatic model_head(input int hp);
        for (int i = 0; i < PRE; i++) push_bit(1'b0, hp);
        push_bit(1'b1, hp);
    endtask

    task automatic model_word(input logic [DATA_W-1:0] w, input int hp);
        for (int i = DATA_W - 1; i >= 0; i--) push_bit(w[i], hp);
    endtask

    task automatic model_tail(input int nwords, input int hp);
        for (int i = 0; i < GAPB * 2 * hp; i++) exp_q.push_back(1'b0);
        len_q.push_back((PRE + 1 + DATA_W * nwords) * 2 * hp + GAPB * 2 * hp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_enable) begin
                run = run + 1;
                if (exp_q.size() == 0) check_val("line_extra", 32'd1, 32'd0);
                else check_val("line", {31'd0, out_data}, {31'd0, exp_q.pop_front()});
            end else if (run != 0) begin
                if (len_q.size() == 0) check_val("frame_extra", run, 0);
                else check_val("en_len", run, len_q.pop_front());
                run = 0;
            end
            if (underrun === 1'b1) begin
                und_cnt = und_cnt + 1;
                und_run = run;
            end
            if (in_ready && busy) rdy_busy = rdy_busy + 1;
        end
    end

    // Present a word from a negedge, wait for in_ready, let the posedge take
    // it, and return at the following negedge with in_valid dropped.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic l, output int acc);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("ready_timeout", 32'd0, 32'd1);
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a0, a1, a2, u0, r0;
        rst         = 1'b1;
        half_period = 8'd4;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;

        // Reset / idle
        repeat (3) @(negedge clk);
        check_val("rst_out_data", {31'd0, out_data}, 32'd0);
        check_val("rst_out_enable", {31'd0, out_enable}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_underrun", {31'd0, underrun}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single word, hp=4
        model_head(4); model_word(30'h2AAAAAAA, 4); model_tail(1, 4);
        send_word(30'h2AAAAAAA, 1'b1, a0);
        wait_done();
        check_val("single_no_underrun", und_cnt, 0);

        // Three-word frame, back to back
        model_head(4);
        model_word(30'h3FFFFFFF, 4); model_word(30'h0, 4); model_word(30'h12345678, 4);
        model_tail(3, 4);
        r0 = rdy_busy;
        send_word(30'h3FFFFFFF, 1'b0, a0);
        send_word(30'h0, 1'b0, a1);
        send_word(30'h12345678, 1'b1, a2);
        check_val("ready_w2_at", a1 - a0, 312);
        check_val("ready_w3_at", a2 - a0, 552);
        wait_done();
        check_val("ready_pulses_3w", rdy_busy - r0, 2);
        check_val("three_no_underrun", und_cnt, 0);

        // Underrun after first word of a non-final frame
        model_head(4); model_word(30'h0F0F0F0F & 30'h3FFFFFFF, 4); model_tail(1, 4);
        u0 = und_cnt;
        r0 = rdy_busy;
        send_word(30'h0F0F0F0F & 30'h3FFFFFFF, 1'b0, a0);
        wait_done();
        check_val("underrun_pulses", und_cnt - u0, 1);
        check_val("underrun_pos", und_run, 313);
        check_val("underrun_ready_pulse", rdy_busy - r0, 1);

        // half_period 0 and 1 clamp to 2
        half_period = 8'd0;
        model_head(eff_hp(0)); model_word(30'h15555555, eff_hp(0)); model_tail(1, eff_hp(0));
        send_word(30'h15555555, 1'b1, a0);
        wait_done();
        half_period = 8'd1;
        model_head(eff_hp(1)); model_word(30'h2ABCDEF1, eff_hp(1)); model_tail(1, eff_hp(1));
        send_word(30'h2ABCDEF1, 1'b1, a0);
        wait_done();

        // half_period changed mid-frame only affects the next frame
        half_period = 8'd4;
        model_head(4); model_word(30'h00C0FFEE, 4); model_tail(1, 4);
        send_word(30'h00C0FFEE, 1'b1, a0);
        repeat (20) @(negedge clk);
        half_period = 8'd10;
        wait_done();
        model_head(10); model_word(30'h3000000F, 10); model_tail(1, 10);
        send_word(30'h3000000F, 1'b1, a0);
        wait_done();

        // Reset at cycle 100 of a frame
        mon_en      = 1'b0;
        half_period = 8'd4;
        send_word(30'h2AAAAAAA, 1'b1, a0);
        repeat (99) @(negedge clk);
        check_val("pre_abort_enable", {31'd0, out_enable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_out_data", {31'd0, out_data}, 32'd0);
        check_val("abort_out_enable", {31'd0, out_enable}, 32'd0);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        len_q.delete();
        run    = 0;
        mon_en = 1'b1;

        // Recovery frame after abort
        half_period = 8'd2;
        model_head(2); model_word(30'h1234ABCD & 30'h3FFFFFFF, 2); model_tail(1, 2);
        send_word(30'h1234ABCD & 30'h3FFFFFFF, 1'b1, a0);
        wait_done();
        check_val("queue_drained", exp_q.size(), 0);
        check_val("frames_drained", len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
